sample_mem_uart_dumper: RTL and testbench
=========================================

Name: sample_mem_uart_dumper

Overview:
Reads back the sample memory that the chromosome evaluation engine fills with 32-bit records {input, inputIndex, expected, chromOut[7:0]}. It streams each word to the host PC over the serial link (UART 8N1). It sits between the capture RAM read port and the board TX pin. A start/busy/done/ack handshake lets the top-level controller sequence evaluate -> dump -> next chromosome.

Parameters:
ADDR_WIDTH, 15, capture RAM address width
DATA_WIDTH, 32, RAM word width; must be a multiple of 8
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be at least 2
BYTES_PER_WORD, DATA_WIDTH/8, bytes transmitted per word

Ports:
iClock  in  1  system clock; all logic on the rising edge
iReset  in  1  asynchronous, active-high reset
iStartDump  in  1  start request; sampled only in IDLE
iLastAddr  in  ADDR_WIDTH  final address to dump; latched on the accepted start
iDoneAck  in  1  host-side acknowledge; releases DONE
oBusy  out  1  high in every state except IDLE and DONE
oDone  out  1  high in DONE
oMemAddr  out  ADDR_WIDTH  RAM read address (registered)
iMemData  in  DATA_WIDTH  RAM q; valid one cycle after the RAM samples oMemAddr
oTxSerial  out  1  UART line; idles high
oWordsSent  out  ADDR_WIDTH+1  count of words fully transmitted in the current dump

Behaviour:
- Reset (async, any state): state=IDLE, oTxSerial=1, oBusy=0, oDone=0, oMemAddr=0, oWordsSent=0, shift register=0, counters=0. Asserting reset mid-frame truncates the frame; the line goes high immediately.
- States: IDLE, MEM_WAIT, LATCH, START_BIT, DATA_BITS, STOP_BIT, NEXT_WORD, DONE.
- IDLE -> MEM_WAIT when iStartDump=1. On that edge: oMemAddr<=0, lastAddr<=iLastAddr, oWordsSent<=0. iStartDump is ignored in all other states.
- MEM_WAIT: one cycle only, to cover the RAM read latency. -> LATCH.
- LATCH: one cycle. wordReg<=iMemData; byteIdx<=BYTES_PER_WORD-1. -> START_BIT.
- Byte order: most significant byte first (byte 3 = input, then index, expected, chromOut).
- Bit order: LSB first within each byte.
- Bit timing: START_BIT drives 0, each DATA_BITS bit drives its data value, STOP_BIT drives 1.
- Each bit is held for exactly CLKS_PER_BIT cycles. A bit timer counts 0..CLKS_PER_BIT-1, and the bit/state advances on the terminal count.
- DATA_BITS ends after 8 bits. STOP_BIT then goes:
  - to START_BIT with byteIdx-1, if byteIdx != 0 (no gap between bytes of a word);
  - to NEXT_WORD, if byteIdx == 0.
- NEXT_WORD: one cycle. oWordsSent<=oWordsSent+1.
  - If oMemAddr==lastAddr -> DONE.
  - Otherwise oMemAddr<=oMemAddr+1 -> MEM_WAIT.
  - The line stays high for 3 cycles between words (NEXT_WORD, MEM_WAIT, LATCH).
- oMemAddr never wraps. With lastAddr = 2^ADDR_WIDTH-1, DONE is reached and oMemAddr is left at all-ones. oWordsSent is 1 bit wider so that 2^ADDR_WIDTH words can be counted.
- DONE: oDone=1, oTxSerial=1, oMemAddr and oWordsSent hold. -> IDLE when iDoneAck=1. iDoneAck in other states has no effect.
- Start in the same cycle as iDoneAck in DONE: go to IDLE only; the start is not accepted.
- Latency:
  - Accepted start -> first start bit: 3 edges (MEM_WAIT, LATCH, START_BIT).
  - One word = 10*BYTES_PER_WORD*CLKS_PER_BIT cycles on the line.
  - N words total from start accept to DONE = 3 + N*(40*CLKS_PER_BIT + 3) - 3 + 1 cycles, i.e. N*(40*CLKS_PER_BIT+3)+1 for the default width.
- iMemData is sampled only in LATCH. Changes at any other time do not affect the word being sent.
- oBusy and oDone are decoded from registered state (glitch-free).

Test Plan:
- Single word, CLKS_PER_BIT=4, iLastAddr=0, RAM[0]=0xA5030FF0 -> line shows bytes A5,03,0F,F0 in that order. Byte A5 reads 0,1,0,1,0,0,1,0,1,1 (start bit, data LSB first, stop bit), each level 4 cycles. Then oWordsSent=1 and oDone=1 at cycle 164 after the accept.
- Three words, iLastAddr=2, RAM[i]=i*0x01010101 -> addresses 0,1,2 are read. Line is high for exactly 3 cycles between words. oWordsSent=3. oMemAddr=2 in DONE.
- Full sweep, ADDR_WIDTH=3, iLastAddr=7 -> 8 words sent, oWordsSent=8 (4'b1000), oMemAddr=7 with no wrap to 0, DONE reached.
- Handshake: iStartDump pulsed while busy -> ignored, and the sequence and addresses are unchanged. Hold oDone with no ack for 100 cycles -> remains DONE. iDoneAck together with iStartDump -> IDLE next cycle, not MEM_WAIT.
- Async reset asserted mid-DATA_BITS of the 2nd byte -> oTxSerial=1 and oBusy=0 with no clock edge. After release, a new start transmits from address 0.
- RAM data changed during transmission (after LATCH) -> transmitted bytes equal the value latched in LATCH.

Source files
------------

// File: rtl/sample_mem_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : sample_mem_uart_dumper
// Description : Reads the capture RAM from address 0 up to a latched last
//               address. Each word goes out on a UART 8N1 line, most
//               significant byte first and LSB first within each byte.
//               A start/busy/done/ack handshake sequences the dumps.
// Ports       : iClock      - system clock, rising edge
//               iReset      - asynchronous active-high reset
//               iStartDump  - start request, honoured only in IDLE
//               iLastAddr   - final address to dump, latched on start
//               iDoneAck    - releases DONE back to IDLE
//               oBusy       - high in all states except IDLE and DONE
//               oDone       - high in DONE
//               oMemAddr    - registered RAM read address
//               iMemData    - RAM q, one cycle after the RAM samples oMemAddr
//               oTxSerial   - UART line, idles high
//               oWordsSent  - words fully transmitted in the current dump
// Revision    : 1.0 - initial release
// ============================================================================
module sample_mem_uart_dumper #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iStartDump,
    input  logic [ADDR_WIDTH-1:0] iLastAddr,
    input  logic                  iDoneAck,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    input  logic [DATA_WIDTH-1:0] iMemData,
    output logic                  oTxSerial,
    output logic [ADDR_WIDTH:0]   oWordsSent
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TMR_W          = $clog2(CLKS_PER_BIT);
    localparam int SEL_W          = $clog2(DATA_WIDTH);
    localparam int CNT_W          = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MEM_WAIT  = 3'd1,
        LATCH     = 3'd2,
        START_BIT = 3'd3,
        DATA_BITS = 3'd4,
        STOP_BIT  = 3'd5,
        NEXT_WORD = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   last_addr, last_addr_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_n;
    logic [CNT_W-1:0]        words_n;
    logic [DATA_WIDTH-1:0]   word_reg, word_n;
    logic [BIDX_W-1:0]       byte_idx, byte_idx_n;
    logic [2:0]              bit_idx, bit_idx_n;
    logic [TMR_W-1:0]        bit_timer, bit_timer_n;
    logic                    tx_n;
    logic                    timer_done;
    logic [SEL_W-1:0]        bit_sel;

    assign timer_done = (bit_timer == TMR_W'(CLKS_PER_BIT - 1));

    // Next-state and next-value logic for the whole datapath
    always_comb begin
        state_n     = state;
        last_addr_n = last_addr;
        mem_addr_n  = oMemAddr;
        words_n     = oWordsSent;
        word_n      = word_reg;
        byte_idx_n  = byte_idx;
        bit_idx_n   = bit_idx;
        bit_timer_n = bit_timer;

        case (state)
            IDLE: begin
                if (iStartDump) begin
                    state_n     = MEM_WAIT;
                    mem_addr_n  = '0;
                    last_addr_n = iLastAddr;
                    words_n     = '0;
                end
            end
            MEM_WAIT: state_n = LATCH;
            LATCH: begin
                word_n      = iMemData;
                byte_idx_n  = BIDX_W'(BYTES_PER_WORD - 1);
                bit_idx_n   = 3'd0;
                bit_timer_n = '0;
                state_n     = START_BIT;
            end
            START_BIT: begin
                if (timer_done) begin
                    bit_timer_n = '0;
                    bit_idx_n   = 3'd0;
                    state_n     = DATA_BITS;
                end else begin
                    bit_timer_n = bit_timer + TMR_W'(1);
                end
            end
            DATA_BITS: begin
                if (timer_done) begin
                    bit_timer_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP_BIT;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_timer_n = bit_timer + TMR_W'(1);
                end
            end
            STOP_BIT: begin
                if (timer_done) begin
                    bit_timer_n = '0;
                    if (byte_idx != '0) begin
                        byte_idx_n = byte_idx - BIDX_W'(1);
                        bit_idx_n  = 3'd0;
                        state_n    = START_BIT;
                    end else begin
                        state_n = NEXT_WORD;
                    end
                end else begin
                    bit_timer_n = bit_timer + TMR_W'(1);
                end
            end
            NEXT_WORD: begin
                words_n = oWordsSent + CNT_W'(1);
                // Stop on the last address instead of incrementing, so the
                // address never wraps even when the full range is dumped.
                if (oMemAddr == last_addr) begin
                    state_n = DONE;
                end else begin
                    mem_addr_n = oMemAddr + ADDR_WIDTH'(1);
                    state_n    = MEM_WAIT;
                end
            end
            DONE: begin
                if (iDoneAck) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The line level is computed from the next state so that it is
    // registered and changes on the same edge as the state it belongs to.
    assign bit_sel = SEL_W'({byte_idx_n, 3'b000}) + SEL_W'(bit_idx_n);

    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START_BIT: tx_n = 1'b0;
            DATA_BITS: tx_n = word_n[bit_sel];
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state      <= IDLE;
            last_addr  <= '0;
            oMemAddr   <= '0;
            oWordsSent <= '0;
            word_reg   <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            bit_timer  <= '0;
            oTxSerial  <= 1'b1;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            state      <= state_n;
            last_addr  <= last_addr_n;
            oMemAddr   <= mem_addr_n;
            oWordsSent <= words_n;
            word_reg   <= word_n;
            byte_idx   <= byte_idx_n;
            bit_idx    <= bit_idx_n;
            bit_timer  <= bit_timer_n;
            oTxSerial  <= tx_n;
            oBusy      <= (state_n != IDLE) && (state_n != DONE);
            oDone      <= (state_n == DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_mem_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_mem_uart_dumper
// Description : Scoreboard bench. Expected UART bytes (value plus idle gap
//               before the start bit) are queued when a dump is started; a
//               negedge UART receiver pops and compares every received byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_mem_uart_dumper;

    localparam int C   = 4;
    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int BPW = DW / 8;
    localparam int WORD_CYC = 10 * BPW * C + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] last_addr;
    logic          ack;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q;
    logic          tx;
    logic [AW:0]   words_sent;

    logic [DW-1:0] ram [1<<AW];

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;

    sample_mem_uart_dumper #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(C)
    ) dut (
        .iClock    (clk),
        .iReset    (rst),
        .iStartDump(start),
        .iLastAddr (last_addr),
        .iDoneAck  (ack),
        .oBusy     (busy),
        .oDone     (done),
        .oMemAddr  (mem_addr),
        .iMemData  (mem_q),
        .oTxSerial (tx),
        .oWordsSent(words_sent)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: q valid one cycle after the address is sampled
    always @(posedge clk) mem_q <= ram[mem_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- UART receiver / scoreboard monitor ----------------
    initial begin
        int         phase    = 0;
        int         idle_cnt = 1000;
        int         gap_seen = 0;
        int         nsamp    = 0;
        logic [10*C-1:0] sv;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase    = 0;
                idle_cnt = 1000;
                nsamp    = 0;
            end else if (phase == 0) begin
                if (tx) begin
                    idle_cnt++;
                end else begin
                    gap_seen = idle_cnt;
                    sv       = '0;
                    nsamp    = 1;
                    phase    = 1;
                end
            end else begin
                sv[nsamp] = tx;
                nsamp++;
                if (nsamp == 10 * C) begin
                    logic       tim_ok;
                    logic [7:0] d;
                    exp_t       e;
                    tim_ok = sv[9*C];
                    for (int g = 0; g < 10; g++)
                        for (int s = 0; s < C; s++)
                            if (sv[g*C+s] != sv[g*C]) tim_ok = 1'b0;
                    for (int i = 0; i < 8; i++) d[i] = sv[(i+1)*C];
                    check("byte_pending", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rx_byte", 64'(d), 64'(e.data));
                        check("bit_timing", 64'(tim_ok), 64'd1);
                        if (e.gap >= 0) check("idle_gap", 64'(gap_seen), 64'(e.gap));
                    end
                    phase    = 0;
                    idle_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_dump(input int last);
        exp_t e;
        for (int a = 0; a <= last; a++) begin
            for (int b = BPW - 1; b >= 0; b--) begin
                e.data = ram[a][b*8 +: 8];
                e.gap  = (a == 0 && b == BPW - 1) ? -1 : ((b == BPW - 1) ? 3 : 0);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        last_addr = AW'(last);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("addr_after_accept", 64'(mem_addr), 64'd0);
    endtask

    // poke_kind 1: start pulse with a different last address while busy
    // poke_kind 2: overwrite RAM word 0 after it has been latched
    task automatic wait_done(input int words, input int poke_at, input int poke_kind);
        int cnt = 1;
        while (!done && cnt < 20000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == poke_at) begin
                if (poke_kind == 1) begin
                    start     = 1'b1;
                    last_addr = AW'((1 << AW) - 1);
                end else if (poke_kind == 2) begin
                    ram[0] = ~ram[0];
                end
            end
            if (cnt == poke_at + 1) start = 1'b0;
        end
        check("done_latency", 64'(cnt), 64'(words * WORD_CYC + 1));
        check("done_flag", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd0);
        check("words_sent", 64'(words_sent), 64'(words));
        check("addr_in_done", 64'(mem_addr), 64'(words - 1));
        check("all_bytes_seen", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("done_released", 64'(done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ack       = 1'b0;
        last_addr = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        #1;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_words", 64'(words_sent), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single directed word
        ram[0] = 32'hA503_0FF0;
        start_dump(0);
        wait_done(1, 0, 0);
        do_ack();

        // Three words with a recognisable pattern
        for (int i = 0; i < 3; i++) ram[i] = 32'(i) * 32'h0101_0101;
        start_dump(2);
        wait_done(3, 0, 0);
        do_ack();

        // Full address range: count needs the extra bit, address must not wrap
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
        start_dump((1 << AW) - 1);
        wait_done(1 << AW, 0, 0);
        do_ack();

        // Start while busy is ignored; DONE holds; ack+start goes to IDLE only
        ram[0] = $urandom;
        ram[1] = $urandom;
        start_dump(1);
        wait_done(2, 60, 1);
        repeat (100) @(posedge clk);
        #1;
        check("done_held", 64'(done), 64'd1);
        check("words_held", 64'(words_sent), 64'd2);
        @(negedge clk);
        ack   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        ack   = 1'b0;
        start = 1'b0;
        check("ack_start_done", 64'(done), 64'd0);
        check("ack_start_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("ack_start_still_idle", 64'(busy), 64'd0);

        // RAM changes after the word is latched must not affect it
        ram[0] = $urandom;
        start_dump(0);
        wait_done(1, 20, 2);
        do_ack();

        // Async reset in the middle of the second byte's data bits
        for (int i = 0; i < 3; i++) ram[i] = $urandom;
        start_dump(2);
        repeat (47) @(posedge clk);
        @(negedge clk);
        #1;
        check("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_tx", 64'(tx), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_addr", 64'(mem_addr), 64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_dump(1);
        wait_done(2, 0, 0);
        do_ack();

        // Randomized dumps
        for (int r = 0; r < 2; r++) begin
            int last;
            for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
            last = $urandom_range(0, (1 << AW) - 1);
            start_dump(last);
            wait_done(last + 1, 0, 0);
            do_ack();
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
